text_term_decoder: RTL and testbench
====================================

# text_term_decoder

Byte-stream terminal decoder sitting directly downstream of the UART receiver. Consumes validated 8-bit bytes (data + 1-cycle valid strobe) and turns them into character/attribute writes into the 80x25 MDA text RAM. It also maintains the hardware cursor position for the display scanout logic. Supports printable characters, CR/LF/BS, and a small ESC command set: set cursor, set attribute, clear screen.

## Interface
Parameters:
- COLS, 80, characters per row
- ROWS, 25, rows per screen
- DEFAULT_ATTR, 8'h07, attribute after reset (normal white-on-black)
- AW (localparam), $clog2(COLS*ROWS) = 11, text RAM address width

Ports:
- i_clk  in  1  clock
- i_rst  in  1  reset, synchronous, active-high
- i_data  in  8  received byte, meaningful only when i_valid=1
- i_valid  in  1  single-cycle byte strobe from UART receiver
- o_wr_en  out  1  text RAM write strobe, one cycle per write
- o_wr_addr  out  AW  write address = row*COLS + col
- o_wr_char  out  8  character code
- o_wr_attr  out  8  attribute byte
- o_cur_row  out  5  cursor row, 0..ROWS-1
- o_cur_col  out  7  cursor column, 0..COLS-1
- o_busy  out  1  high while a clear-screen sweep runs
- o_overrun  out  1  one-cycle pulse when a byte is dropped during o_busy

## Operation
- Reset values:
  - o_wr_en=0, o_wr_addr=0, o_wr_char=0, o_wr_attr=DEFAULT_ATTR.
  - cursor (0,0), attr register=DEFAULT_ATTR, o_busy=0, o_overrun=0, state IDLE.
- States: IDLE, ESC, ARG_ROW, ARG_COL, ARG_ATTR, CLEAR.
- IDLE, byte received:
  - 0x0D: col←0.
  - 0x0A: row←row+1; row ROWS-1 wraps to 0. There is no scrolling.
  - 0x08: col←col-1 if col>0, else unchanged. No write.
  - 0x1B: →ESC.
  - Other 0x00–0x1F: ignored.
  - 0x20–0xFF: write byte at cursor with current attr, then advance col. Col COLS-1 wraps to col 0, row+1, with row wrapping as for LF.
- ESC, next byte:
  - 'P' (0x50): →ARG_ROW.
  - 'A' (0x41): →ARG_ATTR.
  - 'C' (0x43): →CLEAR.
  - Anything else: discarded, →IDLE.
- ARG_ROW: latch row arg, →ARG_COL.
- ARG_COL: cursor←(min(row_arg,ROWS-1), min(col_arg,COLS-1)), →IDLE. Args are raw binary bytes.
- ARG_ATTR: attr←byte, →IDLE.
- CLEAR:
  - Writes 0x20 with current attr to addresses 0..COLS*ROWS-1, one per cycle, ascending.
  - o_busy=1 throughout.
  - After the final write: cursor←(0,0), o_busy←0, →IDLE.
- Bytes arriving in CLEAR are dropped, and each one fires o_overrun for one cycle.
- Bytes arriving in ESC/ARG_* states are never dropped.
- Address arithmetic: row*80 computed as (row<<6)+(row<<4); sum in AW bits, no overflow for legal row/col.

## Timing
- Character write: o_wr_en/addr/char/attr registered, asserted on the cycle after the i_valid cycle.
- The cursor advance takes effect on the same edge as the write, so o_cur_* already shows the new position while o_wr_en is high.
- Control bytes and ESC args: cursor/attr/state update on the edge after i_valid; no write.
- Clear:
  - The first write (addr 0) occurs on the cycle after the 'C' byte.
  - The last write (addr 1999) follows 1999 cycles later.
  - o_busy is high from the first write cycle through the last write cycle inclusive.
  - A byte arriving on the cycle o_busy falls is accepted.
- i_valid is at most one cycle wide. There is no back-pressure; the decoder accepts one byte per cycle outside CLEAR.
- Reset mid-clear or mid-escape: next cycle state IDLE, o_busy=0, o_wr_en=0, all registers at reset values.

## Structure
- Shared package text_term_pkg:
  - state enum.
  - Control codes: CH_CR, CH_LF, CH_BS, CH_ESC.
  - Command letters: CMD_POS, CMD_ATTR, CMD_CLR.
  - Blank char 8'h20.
  - MDA geometry defaults: COLS, ROWS, DEFAULT_ATTR.
- Single module; no sub-module. The clear sweep reuses the write-address counter.

## Test plan
- Reset, send 'H','i' → writes (addr 0,'H',0x07), (addr 1,'i',0x07); cursor (0,2).
- ESC 'P' 24 79, then 'X' → write addr 1999 'X'; cursor wraps to (0,0).
- ESC 'A' 0x70, CR, LF, 'Z' from (3,10) → write addr 320 'Z' attr 0x70; BS at col 0 leaves col 0.
- ESC 'C' → 2000 consecutive writes of 0x20, o_busy high 2000 cycles, cursor (0,0); a byte injected at cycle 500 gives one o_overrun pulse and no write.
- ESC 'P' 200 200 → cursor (24,79); ESC 'Q' → ignored, next 'a' written normally.
- Assert i_rst at clear cycle 100 → o_busy=0 next cycle, no further writes, attr 0x07.

Source files
------------

// File: rtl/text_term_pkg.sv
// Shared types and constants for the MDA text-terminal decoder.
package text_term_pkg;

    localparam int unsigned MDA_COLS         = 80;
    localparam int unsigned MDA_ROWS         = 25;
    localparam logic [7:0]  MDA_DEFAULT_ATTR = 8'h07;

    localparam int unsigned BYTE_W = 8;
    localparam int unsigned ROW_W  = 5;
    localparam int unsigned COL_W  = 7;

    localparam logic [BYTE_W-1:0] CH_CR    = 8'h0D;
    localparam logic [BYTE_W-1:0] CH_LF    = 8'h0A;
    localparam logic [BYTE_W-1:0] CH_BS    = 8'h08;
    localparam logic [BYTE_W-1:0] CH_ESC   = 8'h1B;
    localparam logic [BYTE_W-1:0] CH_BLANK = 8'h20;

    localparam logic [BYTE_W-1:0] CMD_POS  = 8'h50;
    localparam logic [BYTE_W-1:0] CMD_ATTR = 8'h41;
    localparam logic [BYTE_W-1:0] CMD_CLR  = 8'h43;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ESC,
        ST_ARG_ROW,
        ST_ARG_COL,
        ST_ARG_ATTR,
        ST_CLEAR
    } state_t;

    // Row start offset for an 80-column screen, built from shifts instead of a multiplier.
    function automatic logic [15:0] row_x80(input logic [ROW_W-1:0] row);
        return (16'(row) << 6) + (16'(row) << 4);
    endfunction

endpackage

// File: rtl/text_term_decoder_if.sv
// Byte-in / text-RAM-write-out bundle between the UART receiver, decoder and scanout.
interface text_term_decoder_if
    import text_term_pkg::*;
#(
    parameter int unsigned AW = 11
);
    logic [BYTE_W-1:0] i_data;
    logic              i_valid;
    logic              o_wr_en;
    logic [AW-1:0]     o_wr_addr;
    logic [BYTE_W-1:0] o_wr_char;
    logic [BYTE_W-1:0] o_wr_attr;
    logic [ROW_W-1:0]  o_cur_row;
    logic [COL_W-1:0]  o_cur_col;
    logic              o_busy;
    logic              o_overrun;

    modport master (
        output i_data, i_valid,
        input  o_wr_en, o_wr_addr, o_wr_char, o_wr_attr,
        input  o_cur_row, o_cur_col, o_busy, o_overrun
    );

    modport slave (
        input  i_data, i_valid,
        output o_wr_en, o_wr_addr, o_wr_char, o_wr_attr,
        output o_cur_row, o_cur_col, o_busy, o_overrun
    );
endinterface

// File: rtl/text_term_decoder.sv
// Turns received bytes into MDA text-RAM writes, tracks the cursor and runs the ESC command set.
module text_term_decoder
    import text_term_pkg::*;
#(
    parameter int unsigned COLS         = MDA_COLS,
    parameter int unsigned ROWS         = MDA_ROWS,
    parameter logic [7:0]  DEFAULT_ATTR = MDA_DEFAULT_ATTR
) (
    input logic                i_clk,
    input logic                i_rst,
    text_term_decoder_if.slave bus
);
    localparam int unsigned       AW        = $clog2(COLS * ROWS);
    localparam logic [AW-1:0]     LAST_ADDR = AW'(COLS * ROWS - 1);
    localparam logic [ROW_W-1:0]  ROW_MAX   = ROW_W'(ROWS - 1);
    localparam logic [COL_W-1:0]  COL_MAX   = COL_W'(COLS - 1);

    state_t            state, state_nxt;
    logic [ROW_W-1:0]  row, row_nxt, row_inc;
    logic [COL_W-1:0]  col, col_nxt;
    logic [BYTE_W-1:0] attr, attr_nxt;
    logic [BYTE_W-1:0] row_arg, row_arg_nxt;
    logic              wr_en, wr_en_nxt;
    logic [AW-1:0]     wr_addr, wr_addr_nxt;
    logic [BYTE_W-1:0] wr_char, wr_char_nxt;
    logic [BYTE_W-1:0] wr_attr, wr_attr_nxt;
    logic              busy, busy_nxt;
    logic              overrun, overrun_nxt;

    always_ff @(posedge i_clk) begin
        if (i_rst) state <= ST_IDLE;
        else       state <= state_nxt;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            row     <= '0;
            col     <= '0;
            attr    <= DEFAULT_ATTR;
            row_arg <= '0;
            wr_en   <= 1'b0;
            wr_addr <= '0;
            wr_char <= '0;
            wr_attr <= DEFAULT_ATTR;
            busy    <= 1'b0;
            overrun <= 1'b0;
        end else begin
            row     <= row_nxt;
            col     <= col_nxt;
            attr    <= attr_nxt;
            row_arg <= row_arg_nxt;
            wr_en   <= wr_en_nxt;
            wr_addr <= wr_addr_nxt;
            wr_char <= wr_char_nxt;
            wr_attr <= wr_attr_nxt;
            busy    <= busy_nxt;
            overrun <= overrun_nxt;
        end
    end

    assign row_inc = (row == ROW_MAX) ? '0 : row + ROW_W'(1);

    always_comb begin
        state_nxt   = state;
        row_nxt     = row;
        col_nxt     = col;
        attr_nxt    = attr;
        row_arg_nxt = row_arg;
        wr_en_nxt   = 1'b0;
        wr_addr_nxt = wr_addr;
        wr_char_nxt = wr_char;
        wr_attr_nxt = wr_attr;
        busy_nxt    = busy;
        overrun_nxt = 1'b0;

        unique case (state)
            ST_IDLE: begin
                if (bus.i_valid) begin
                    if (bus.i_data == CH_CR) begin
                        col_nxt = '0;
                    end else if (bus.i_data == CH_LF) begin
                        row_nxt = row_inc;
                    end else if (bus.i_data == CH_BS) begin
                        if (col != '0) col_nxt = col - COL_W'(1);
                    end else if (bus.i_data == CH_ESC) begin
                        state_nxt = ST_ESC;
                    end else if (bus.i_data >= CH_BLANK) begin
                        wr_en_nxt   = 1'b1;
                        wr_addr_nxt = AW'(row_x80(row)) + AW'(col);
                        wr_char_nxt = bus.i_data;
                        wr_attr_nxt = attr;
                        if (col == COL_MAX) begin
                            col_nxt = '0;
                            row_nxt = row_inc;
                        end else begin
                            col_nxt = col + COL_W'(1);
                        end
                    end
                end
            end
            ST_ESC: begin
                if (bus.i_valid) begin
                    if (bus.i_data == CMD_POS) begin
                        state_nxt = ST_ARG_ROW;
                    end else if (bus.i_data == CMD_ATTR) begin
                        state_nxt = ST_ARG_ATTR;
                    end else if (bus.i_data == CMD_CLR) begin
                        // First blank lands on the same edge that enters the sweep.
                        state_nxt   = ST_CLEAR;
                        wr_en_nxt   = 1'b1;
                        wr_addr_nxt = '0;
                        wr_char_nxt = CH_BLANK;
                        wr_attr_nxt = attr;
                        busy_nxt    = 1'b1;
                    end else begin
                        state_nxt = ST_IDLE;
                    end
                end
            end
            ST_ARG_ROW: begin
                if (bus.i_valid) begin
                    row_arg_nxt = bus.i_data;
                    state_nxt   = ST_ARG_COL;
                end
            end
            ST_ARG_COL: begin
                if (bus.i_valid) begin
                    row_nxt   = (row_arg > BYTE_W'(ROWS - 1)) ? ROW_MAX : row_arg[ROW_W-1:0];
                    col_nxt   = (bus.i_data > BYTE_W'(COLS - 1)) ? COL_MAX : bus.i_data[COL_W-1:0];
                    state_nxt = ST_IDLE;
                end
            end
            ST_ARG_ATTR: begin
                if (bus.i_valid) begin
                    attr_nxt  = bus.i_data;
                    state_nxt = ST_IDLE;
                end
            end
            ST_CLEAR: begin
                overrun_nxt = bus.i_valid;
                if (wr_addr == LAST_ADDR) begin
                    state_nxt = ST_IDLE;
                    busy_nxt  = 1'b0;
                    row_nxt   = '0;
                    col_nxt   = '0;
                end else begin
                    wr_en_nxt   = 1'b1;
                    wr_addr_nxt = wr_addr + AW'(1);
                    wr_char_nxt = CH_BLANK;
                    wr_attr_nxt = attr;
                    busy_nxt    = 1'b1;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    assign bus.o_wr_en   = wr_en;
    assign bus.o_wr_addr = wr_addr;
    assign bus.o_wr_char = wr_char;
    assign bus.o_wr_attr = wr_attr;
    assign bus.o_cur_row = row;
    assign bus.o_cur_col = col;
    assign bus.o_busy    = busy;
    assign bus.o_overrun = overrun;

endmodule

// File: tb/tb_text_term_decoder.sv
// Directed bench for text_term_decoder: characters, control codes, ESC commands, clear sweep, reset.
module tb_text_term_decoder;
    import text_term_pkg::*;

    logic i_clk;
    logic i_rst;
    int   checks;
    int   errors;

    text_term_decoder_if bus ();

    text_term_decoder dut (
        .i_clk (i_clk),
        .i_rst (i_rst),
        .bus   (bus.slave)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    // Present one byte for exactly one cycle; returns 1 time unit after the capturing edge.
    task automatic send(input logic [7:0] b);
        bus.i_data  = b;
        bus.i_valid = 1'b1;
        @(posedge i_clk);
        #1;
        bus.i_valid = 1'b0;
    endtask

    task automatic idle_cycle();
        @(posedge i_clk);
        #1;
    endtask

    task automatic test_reset();
        i_rst = 1'b1;
        idle_cycle();
        idle_cycle();
        i_rst = 1'b0;
        checks++; if (bus.o_wr_en !== 1'b0) begin errors++; $display("FAIL reset_wr_en got %0b want 0", bus.o_wr_en); end
        checks++; if (bus.o_wr_addr !== 11'd0) begin errors++; $display("FAIL reset_wr_addr got %0d want 0", bus.o_wr_addr); end
        checks++; if (bus.o_wr_char !== 8'h00) begin errors++; $display("FAIL reset_wr_char got %h want 00", bus.o_wr_char); end
        checks++; if (bus.o_wr_attr !== 8'h07) begin errors++; $display("FAIL reset_wr_attr got %h want 07", bus.o_wr_attr); end
        checks++; if (bus.o_cur_row !== 5'd0 || bus.o_cur_col !== 7'd0) begin errors++; $display("FAIL reset_cursor got (%0d,%0d) want (0,0)", bus.o_cur_row, bus.o_cur_col); end
        checks++; if (bus.o_busy !== 1'b0 || bus.o_overrun !== 1'b0) begin errors++; $display("FAIL reset_busy_ovr got %0b%0b want 00", bus.o_busy, bus.o_overrun); end
    endtask

    task automatic test_chars();
        send(8'h48);
        checks++; if (bus.o_wr_en !== 1'b1 || bus.o_wr_addr !== 11'd0 || bus.o_wr_char !== 8'h48 || bus.o_wr_attr !== 8'h07)
            begin errors++; $display("FAIL char_H got en=%0b a=%0d c=%h t=%h want 1 0 48 07", bus.o_wr_en, bus.o_wr_addr, bus.o_wr_char, bus.o_wr_attr); end
        checks++; if (bus.o_cur_col !== 7'd1) begin errors++; $display("FAIL char_H_col got %0d want 1", bus.o_cur_col); end
        send(8'h69);
        checks++; if (bus.o_wr_en !== 1'b1 || bus.o_wr_addr !== 11'd1 || bus.o_wr_char !== 8'h69 || bus.o_wr_attr !== 8'h07)
            begin errors++; $display("FAIL char_i got en=%0b a=%0d c=%h t=%h want 1 1 69 07", bus.o_wr_en, bus.o_wr_addr, bus.o_wr_char, bus.o_wr_attr); end
        checks++; if (bus.o_cur_row !== 5'd0 || bus.o_cur_col !== 7'd2) begin errors++; $display("FAIL char_i_cursor got (%0d,%0d) want (0,2)", bus.o_cur_row, bus.o_cur_col); end
        idle_cycle();
        checks++; if (bus.o_wr_en !== 1'b0) begin errors++; $display("FAIL char_strobe_width got %0b want 0", bus.o_wr_en); end
        send(8'h01);
        checks++; if (bus.o_wr_en !== 1'b0 || bus.o_cur_col !== 7'd2) begin errors++; $display("FAIL ctrl_ignored got en=%0b col=%0d want 0 2", bus.o_wr_en, bus.o_cur_col); end
    endtask

    task automatic test_wrap();
        send(CH_ESC); send(CMD_POS); send(8'd24); send(8'd79);
        checks++; if (bus.o_cur_row !== 5'd24 || bus.o_cur_col !== 7'd79 || bus.o_wr_en !== 1'b0)
            begin errors++; $display("FAIL pos_24_79 got (%0d,%0d) en=%0b want (24,79) 0", bus.o_cur_row, bus.o_cur_col, bus.o_wr_en); end
        send(8'h58);
        checks++; if (bus.o_wr_en !== 1'b1 || bus.o_wr_addr !== 11'd1999 || bus.o_wr_char !== 8'h58)
            begin errors++; $display("FAIL wrap_write got en=%0b a=%0d c=%h want 1 1999 58", bus.o_wr_en, bus.o_wr_addr, bus.o_wr_char); end
        checks++; if (bus.o_cur_row !== 5'd0 || bus.o_cur_col !== 7'd0) begin errors++; $display("FAIL wrap_cursor got (%0d,%0d) want (0,0)", bus.o_cur_row, bus.o_cur_col); end
    endtask

    task automatic test_attr_ctrl();
        send(CH_ESC); send(CMD_POS); send(8'd3); send(8'd10);
        send(CH_ESC); send(CMD_ATTR); send(8'h70);
        send(CH_CR);
        checks++; if (bus.o_cur_row !== 5'd3 || bus.o_cur_col !== 7'd0) begin errors++; $display("FAIL cr got (%0d,%0d) want (3,0)", bus.o_cur_row, bus.o_cur_col); end
        send(CH_LF);
        checks++; if (bus.o_cur_row !== 5'd4 || bus.o_wr_en !== 1'b0) begin errors++; $display("FAIL lf got row=%0d en=%0b want 4 0", bus.o_cur_row, bus.o_wr_en); end
        send(8'h5A);
        checks++; if (bus.o_wr_en !== 1'b1 || bus.o_wr_addr !== 11'd320 || bus.o_wr_char !== 8'h5A || bus.o_wr_attr !== 8'h70)
            begin errors++; $display("FAIL attr_write got en=%0b a=%0d c=%h t=%h want 1 320 5a 70", bus.o_wr_en, bus.o_wr_addr, bus.o_wr_char, bus.o_wr_attr); end
        send(CH_BS);
        checks++; if (bus.o_cur_col !== 7'd0 || bus.o_wr_en !== 1'b0) begin errors++; $display("FAIL bs got col=%0d en=%0b want 0 0", bus.o_cur_col, bus.o_wr_en); end
        send(CH_BS);
        checks++; if (bus.o_cur_col !== 7'd0 || bus.o_cur_row !== 5'd4) begin errors++; $display("FAIL bs_at_zero got (%0d,%0d) want (4,0)", bus.o_cur_row, bus.o_cur_col); end
    endtask

    task automatic test_clear();
        int k, writes, busy_cnt, ovr, bad;
        logic [10:0] exp_addr;
        writes = 0; busy_cnt = 0; ovr = 0; bad = 0; exp_addr = 11'd0; k = 0;
        send(CH_ESC);
        send(CMD_CLR);
        checks++; if (bus.o_wr_en !== 1'b1 || bus.o_wr_addr !== 11'd0 || bus.o_busy !== 1'b1)
            begin errors++; $display("FAIL clear_first got en=%0b a=%0d busy=%0b want 1 0 1", bus.o_wr_en, bus.o_wr_addr, bus.o_busy); end
        while (bus.o_busy === 1'b1 && k < 2100) begin
            if (bus.o_wr_en === 1'b1) begin
                if (bus.o_wr_addr !== exp_addr || bus.o_wr_char !== 8'h20 || bus.o_wr_attr !== 8'h70) bad++;
                exp_addr = exp_addr + 11'd1;
                writes++;
            end
            busy_cnt++;
            if (bus.o_overrun === 1'b1) ovr++;
            if (k == 500) begin bus.i_data = 8'h51; bus.i_valid = 1'b1; end
            @(posedge i_clk);
            #1;
            bus.i_valid = 1'b0;
            k++;
        end
        checks++; if (k >= 2100) begin errors++; $display("FAIL clear_timeout got %0d cycles want <2100", k); end
        checks++; if (bad != 0) begin errors++; $display("FAIL clear_sequence got %0d bad writes want 0", bad); end
        checks++; if (writes != 2000) begin errors++; $display("FAIL clear_writes got %0d want 2000", writes); end
        checks++; if (busy_cnt != 2000) begin errors++; $display("FAIL clear_busy_cycles got %0d want 2000", busy_cnt); end
        checks++; if (ovr != 1) begin errors++; $display("FAIL clear_overrun got %0d want 1", ovr); end
        checks++; if (bus.o_wr_en !== 1'b0 || bus.o_cur_row !== 5'd0 || bus.o_cur_col !== 7'd0)
            begin errors++; $display("FAIL clear_end got en=%0b (%0d,%0d) want 0 (0,0)", bus.o_wr_en, bus.o_cur_row, bus.o_cur_col); end
        send(8'h61);
        checks++; if (bus.o_wr_en !== 1'b1 || bus.o_wr_addr !== 11'd0 || bus.o_wr_char !== 8'h61 || bus.o_wr_attr !== 8'h70)
            begin errors++; $display("FAIL clear_fall_accept got en=%0b a=%0d c=%h t=%h want 1 0 61 70", bus.o_wr_en, bus.o_wr_addr, bus.o_wr_char, bus.o_wr_attr); end
    endtask

    task automatic test_clamp_and_bad_esc();
        send(CH_ESC); send(CMD_POS); send(8'd200); send(8'd200);
        checks++; if (bus.o_cur_row !== 5'd24 || bus.o_cur_col !== 7'd79) begin errors++; $display("FAIL clamp got (%0d,%0d) want (24,79)", bus.o_cur_row, bus.o_cur_col); end
        send(CH_ESC); send(8'h51);
        checks++; if (bus.o_wr_en !== 1'b0 || bus.o_cur_row !== 5'd24 || bus.o_cur_col !== 7'd79)
            begin errors++; $display("FAIL bad_esc got en=%0b (%0d,%0d) want 0 (24,79)", bus.o_wr_en, bus.o_cur_row, bus.o_cur_col); end
        send(8'h61);
        checks++; if (bus.o_wr_en !== 1'b1 || bus.o_wr_addr !== 11'd1999 || bus.o_wr_char !== 8'h61 || bus.o_wr_attr !== 8'h70)
            begin errors++; $display("FAIL after_bad_esc got en=%0b a=%0d c=%h t=%h want 1 1999 61 70", bus.o_wr_en, bus.o_wr_addr, bus.o_wr_char, bus.o_wr_attr); end
    endtask

    task automatic test_reset_mid_clear();
        int stray;
        stray = 0;
        send(CH_ESC);
        send(CMD_CLR);
        for (int i = 0; i < 100; i++) idle_cycle();
        checks++; if (bus.o_busy !== 1'b1 || bus.o_wr_addr !== 11'd100) begin errors++; $display("FAIL pre_reset got busy=%0b a=%0d want 1 100", bus.o_busy, bus.o_wr_addr); end
        i_rst = 1'b1;
        idle_cycle();
        i_rst = 1'b0;
        checks++; if (bus.o_busy !== 1'b0 || bus.o_wr_en !== 1'b0 || bus.o_wr_attr !== 8'h07 || bus.o_wr_addr !== 11'd0)
            begin errors++; $display("FAIL mid_clear_reset got busy=%0b en=%0b t=%h a=%0d want 0 0 07 0", bus.o_busy, bus.o_wr_en, bus.o_wr_attr, bus.o_wr_addr); end
        for (int i = 0; i < 50; i++) begin
            idle_cycle();
            if (bus.o_wr_en !== 1'b0 || bus.o_busy !== 1'b0) stray++;
        end
        checks++; if (stray != 0) begin errors++; $display("FAIL post_reset_writes got %0d want 0", stray); end
        send(8'h62);
        checks++; if (bus.o_wr_attr !== 8'h07 || bus.o_wr_addr !== 11'd0 || bus.o_wr_char !== 8'h62)
            begin errors++; $display("FAIL post_reset_char got a=%0d c=%h t=%h want 0 62 07", bus.o_wr_addr, bus.o_wr_char, bus.o_wr_attr); end
        // Reset inside an escape must drop the pending command.
        send(CH_ESC); send(CMD_POS);
        i_rst = 1'b1;
        idle_cycle();
        i_rst = 1'b0;
        send(8'h50);
        checks++; if (bus.o_wr_en !== 1'b1 || bus.o_wr_char !== 8'h50 || bus.o_wr_addr !== 11'd0)
            begin errors++; $display("FAIL mid_esc_reset got en=%0b c=%h a=%0d want 1 50 0", bus.o_wr_en, bus.o_wr_char, bus.o_wr_addr); end
    endtask

    initial begin
        checks      = 0;
        errors      = 0;
        i_rst       = 1'b1;
        bus.i_data  = 8'h00;
        bus.i_valid = 1'b0;
        @(posedge i_clk);
        #1;
        test_reset();
        test_chars();
        test_wrap();
        test_attr_ctrl();
        test_clear();
        test_clamp_and_bad_esc();
        test_reset_mid_clear();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
